// File: rtl/pkg_ula.sv
// pkg_ula: shared opcodes, controller state encoding, instruction field positions and width defaults for the ULA sequencer
package pkg_ula;
  localparam int LARG_PC_DEF     = 12;
  localparam int LARG_DADO_DEF   = 16;
  localparam int TIMEOUT_MEM_DEF = 15;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ULT = 4'b1010;
  localparam logic [3:0] OP_JMP = 4'b1011;
  localparam logic [3:0] OP_BEZ = 4'b1100;
  localparam logic [3:0] OP_MLO = 4'b1101;
  localparam logic [3:0] OP_MHI = 4'b1110;
  localparam logic [3:0] OP_INI = 4'b1111;
  localparam int F_OP    = 12;
  localparam int F_RD    = 8;
  localparam int F_S2    = 4;
  localparam int F_S3    = 0;
  localparam int IMM_MSB = 11;
  typedef enum logic [2:0] {
    BUSCA, ESPERA_MEM, DECOD, ESPERA_MUL, EXEC, ESCRITA, HALT, ERRO
  } estado_t;
endpackage

// File: rtl/decodif_instr.sv
// decodif_instr: combinational decode of instr into codop/rd/s2/s3/imm and class flags (salto, desvio, mul, halt, escreve_reg)
module decodif_instr
  import pkg_ula::*;
#(
  parameter int LARG_DADO = LARG_DADO_DEF
) (
  input  logic [LARG_DADO-1:0] instr,
  output logic [3:0]           codop,
  output logic [3:0]           rd,
  output logic [3:0]           s2,
  output logic [3:0]           s3,
  output logic [LARG_DADO-1:0] imm,
  output logic                 eh_salto,
  output logic                 eh_desvio,
  output logic                 eh_mul,
  output logic                 eh_halt,
  output logic                 escreve_reg
);
  assign codop       = instr[F_OP +: 4];
  assign rd          = instr[F_RD +: 4];
  assign s2          = instr[F_S2 +: 4];
  assign s3          = instr[F_S3 +: 4];
  assign imm         = LARG_DADO'(instr[IMM_MSB:0]);
  assign eh_salto    = codop == OP_JMP;
  assign eh_desvio   = codop == OP_BEZ;
  assign eh_mul      = codop == OP_MLO || codop == OP_MHI;
  assign eh_halt     = codop == OP_INI;
  assign escreve_reg = codop <= OP_ULT || eh_mul;
endmodule

// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle sequencer (fetch req/ack, decode, ULA drive, regfile strobes, PC, mul stall, halt, fetch timeout)
module unidade_controle
  import pkg_ula::*;
#(
  parameter int LARG_PC     = LARG_PC_DEF,
  parameter int LARG_DADO   = LARG_DADO_DEF,
  parameter int TIMEOUT_MEM = TIMEOUT_MEM_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 im_req,
  output logic [LARG_PC-1:0]   im_addr,
  input  logic                 im_ack,
  input  logic [LARG_DADO-1:0] im_data,
  input  logic [LARG_DADO-1:0] rf_db,
  input  logic                 mul_valido,
  input  logic                 retomar,
  output logic [3:0]           codop,
  output logic [3:0]           s2,
  output logic [3:0]           s3,
  output logic [LARG_DADO-1:0] imm,
  output logic [1:0]           fontecp,
  output logic                 ula_en,
  output logic [3:0]           rf_ra,
  output logic [3:0]           rf_rb,
  output logic                 rf_we,
  output logic [3:0]           rf_wa,
  output logic [LARG_PC-1:0]   pc,
  output logic                 ocupado,
  output logic                 erro
);
  estado_t              estado, prox;
  logic [LARG_DADO-1:0] instr;
  logic [3:0]           cnt;
  logic [LARG_PC-1:0]   pc_prox;
  logic [3:0]           rd;
  logic                 eh_salto, eh_desvio, eh_mul, eh_halt, escreve_reg;
  decodif_instr #(.LARG_DADO(LARG_DADO)) u_dec (
    .instr      (instr),
    .codop      (codop),
    .rd         (rd),
    .s2         (s2),
    .s3         (s3),
    .imm        (imm),
    .eh_salto   (eh_salto),
    .eh_desvio  (eh_desvio),
    .eh_mul     (eh_mul),
    .eh_halt    (eh_halt),
    .escreve_reg(escreve_reg)
  );
  always_comb begin
    prox    = estado;
    pc_prox = pc;
    case (estado)
      BUSCA:      prox = ESPERA_MEM;
      ESPERA_MEM: prox = im_ack ? DECOD : (cnt == 4'(TIMEOUT_MEM - 1)) ? ERRO : ESPERA_MEM;
      DECOD:      prox = (eh_mul && !mul_valido) ? ESPERA_MUL : EXEC;
      ESPERA_MUL: prox = mul_valido ? EXEC : ESPERA_MUL;
      EXEC: begin
        prox    = escreve_reg ? ESCRITA : eh_halt ? HALT : BUSCA;
        pc_prox = eh_salto ? LARG_PC'(imm) : eh_desvio ? ((rf_db == '0) ? LARG_PC'(s2) : pc + 1'b1) : pc;
      end
      ESCRITA: begin
        prox    = BUSCA;
        pc_prox = pc + 1'b1;
      end
      HALT: begin
        prox    = retomar ? BUSCA : HALT;
        pc_prox = retomar ? pc + 1'b1 : pc;
      end
      default: prox = ERRO;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= BUSCA;
      pc     <= '0;
      cnt    <= '0;
      instr  <= '0;
    end else begin
      estado <= prox;
      pc     <= pc_prox;
      cnt    <= (estado == ESPERA_MEM && !im_ack) ? cnt + 1'b1 : '0;
      if (estado == ESPERA_MEM && im_ack) instr <= im_data;
    end
  end
  assign im_req  = estado == BUSCA || estado == ESPERA_MEM;
  assign im_addr = pc;
  assign ula_en  = estado == EXEC;
  assign fontecp = ula_en ? 2'b01 : 2'b00;
  assign rf_ra   = s2;
  assign rf_rb   = s3;
  assign rf_we   = estado == ESCRITA;
  assign rf_wa   = rd;
  assign ocupado = estado != HALT;
  assign erro    = estado == ERRO;
endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: randomized scoreboard bench for unidade_controle against an architectural PC/event model
module tb_unidade_controle;
  logic        clock = 1'b0, reset = 1'b1, im_ack = 1'b0, mul_valido = 1'b0, retomar = 1'b0;
  logic [15:0] im_data = '0, rf_db = '0;
  logic        im_req, ula_en, rf_we, ocupado, erro;
  logic [11:0] im_addr, pc;
  logic [3:0]  codop, s2, s3, rf_ra, rf_rb, rf_wa;
  logic [15:0] imm;
  logic [1:0]  fontecp;
  unidade_controle dut (
    .clock(clock), .reset(reset), .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack),
    .im_data(im_data), .rf_db(rf_db), .mul_valido(mul_valido), .retomar(retomar),
    .codop(codop), .s2(s2), .s3(s3), .imm(imm), .fontecp(fontecp), .ula_en(ula_en),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_we(rf_we), .rf_wa(rf_wa), .pc(pc),
    .ocupado(ocupado), .erro(erro)
  );
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  int n_tests = 0, n_fail = 0;
  typedef struct {int c; logic [3:0] op; logic [3:0] s2; logic [3:0] s3; logic [15:0] imm;} ula_t;
  typedef struct {int c; logic [3:0] wa;} we_t;
  typedef struct {int c; logic [11:0] addr;} fet_t;
  ula_t q_ula[$];
  we_t  q_we[$];
  fet_t q_fet[$];
  int   q_halt[$];
  logic [11:0] mpc = '0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", nm, got, exp, cyc);
    end
  endtask
  logic req_prev = 1'b0, oc_prev = 1'b1;
  always @(negedge clock) begin
    if (reset) begin
      req_prev <= 1'b0;
      oc_prev  <= 1'b1;
    end else begin
      if (ula_en) begin
        if (q_ula.size() == 0) chk("ula_spurious", 32'(ula_en), 32'd0);
        else begin
          chk("ula_cyc", 32'(cyc), 32'(q_ula[0].c));
          chk("codop", 32'(codop), 32'(q_ula[0].op));
          chk("s2", 32'(s2), 32'(q_ula[0].s2));
          chk("s3", 32'(s3), 32'(q_ula[0].s3));
          chk("rf_ra", 32'(rf_ra), 32'(q_ula[0].s2));
          chk("rf_rb", 32'(rf_rb), 32'(q_ula[0].s3));
          chk("imm", 32'(imm), 32'(q_ula[0].imm));
          chk("fontecp", 32'(fontecp), 32'd1);
          void'(q_ula.pop_front());
        end
      end
      if (rf_we) begin
        chk("we_with_ula", 32'(ula_en), 32'd0);
        if (q_we.size() == 0) chk("we_spurious", 32'(rf_we), 32'd0);
        else begin
          chk("we_cyc", 32'(cyc), 32'(q_we[0].c));
          chk("rf_wa", 32'(rf_wa), 32'(q_we[0].wa));
          void'(q_we.pop_front());
        end
      end
      if (im_req && !req_prev) begin
        if (q_fet.size() == 0) chk("fetch_spurious", 32'(im_req), 32'd0);
        else begin
          chk("fetch_cyc", 32'(cyc), 32'(q_fet[0].c));
          chk("im_addr", 32'(im_addr), 32'(q_fet[0].addr));
          chk("pc", 32'(pc), 32'(q_fet[0].addr));
          void'(q_fet.pop_front());
        end
      end
      if (!ocupado && oc_prev) begin
        if (q_halt.size() == 0) chk("halt_spurious", 32'(ocupado), 32'd1);
        else begin
          chk("halt_cyc", 32'(cyc), 32'(q_halt[0]));
          void'(q_halt.pop_front());
        end
      end
      req_prev <= im_req;
      oc_prev  <= ocupado;
    end
  end
  task automatic wait_req(output int c);
    c = -1;
    for (int i = 0; i < 60; i++) begin
      if (im_req) begin
        c = cyc;
        break;
      end
      @(posedge clock); #1;
    end
  endtask
  task automatic step(input logic [15:0] ins, input int w, input int k, input logic [15:0] db, input int h);
    int c, a, e;
    logic [3:0] op;
    logic mul;
    op  = ins[15:12];
    mul = op == 4'hD || op == 4'hE;
    wait_req(c);
    if (c < 0) begin
      chk("fetch_wait", 32'(im_req), 32'd1);
      return;
    end
    repeat (w) begin @(posedge clock); #1; end
    im_ack  = 1'b1;
    im_data = ins;
    rf_db   = db;
    retomar = (op != 4'hF) && ($urandom_range(0, 3) == 0);
    a = cyc;
    @(posedge clock); #1;
    im_ack     = 1'b0;
    im_data    = 16'($urandom);
    retomar    = 1'b0;
    mul_valido = mul ? (k == 0) : 1'($urandom);
    e = a + 2 + (mul ? k : 0);
    q_ula.push_back('{e, op, ins[7:4], ins[3:0], {4'h0, ins[11:0]}});
    if (op <= 4'hA || mul) begin
      q_we.push_back('{e + 1, ins[11:8]});
      mpc = mpc + 12'd1;
      q_fet.push_back('{e + 2, mpc});
    end else if (op == 4'hB) begin
      mpc = ins[11:0];
      q_fet.push_back('{e + 1, mpc});
    end else if (op == 4'hC) begin
      mpc = (db == 16'h0) ? {8'h00, ins[7:4]} : mpc + 12'd1;
      q_fet.push_back('{e + 1, mpc});
    end else begin
      q_halt.push_back(e + 1);
      mpc = mpc + 12'd1;
      q_fet.push_back('{e + 2 + h, mpc});
    end
    if (mul) begin
      repeat (k) begin @(posedge clock); #1; end
      mul_valido = 1'b1;
    end
    if (op == 4'hF) begin
      while (cyc < e + 1 + h) begin @(posedge clock); #1; end
      retomar = 1'b1;
      @(posedge clock); #1;
      retomar = 1'b0;
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int c;
    logic [15:0] ins;
    repeat (3) @(posedge clock);
    #1;
    q_fet.push_back('{cyc, 12'h000});
    reset = 1'b0;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_erro", 32'(erro), 32'd0);
    chk("rst_ula_en", 32'(ula_en), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_codop", 32'(codop), 32'd0);
    step(16'h0312, 1, 0, 16'h0005, 0);
    step(16'hB0A5, 1, 0, 16'h0005, 0);
    step(16'hC070, 2, 0, 16'h0000, 0);
    step(16'hC070, 1, 0, 16'h0001, 0);
    step(16'hD400, 1, 6, 16'h0000, 0);
    step(16'hBFFF, 3, 0, 16'h0000, 0);
    step(16'hF000, 1, 0, 16'h0000, 2);
    for (int i = 0; i < 120; i++) begin
      ins = 16'($urandom);
      step(ins, $urandom_range(1, 4), $urandom_range(0, 5),
           ($urandom_range(0, 1) == 1) ? 16'h0 : 16'($urandom), $urandom_range(0, 3));
    end
    wait_req(c);
    chk("to_req_seen", 32'(im_req), 32'd1);
    while (cyc < c + 15) begin @(posedge clock); #1; end
    chk("to_erro_before", 32'(erro), 32'd0);
    chk("to_req_before", 32'(im_req), 32'd1);
    @(posedge clock); #1;
    chk("to_erro_set", 32'(erro), 32'd1);
    chk("to_req_drop", 32'(im_req), 32'd0);
    repeat (4) begin @(posedge clock); #1; end
    im_ack = 1'b1;
    @(posedge clock); #1;
    im_ack = 1'b0;
    @(posedge clock); #1;
    chk("err_sticky", 32'(erro), 32'd1);
    chk("err_req", 32'(im_req), 32'd0);
    chk("err_ula", 32'(ula_en), 32'd0);
    chk("err_pc", 32'(pc), 32'(mpc));
    q_fet.push_back('{cyc + 1, 12'h000});
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rst2_pc", 32'(pc), 32'd0);
    chk("rst2_erro", 32'(erro), 32'd0);
    chk("rst2_req", 32'(im_req), 32'd1);
    chk("rst2_ula_en", 32'(ula_en), 32'd0);
    chk("rst2_rf_we", 32'(rf_we), 32'd0);
    repeat (2) begin @(posedge clock); #1; end
    chk("left_ula", 32'(q_ula.size()), 32'd0);
    chk("left_we", 32'(q_we.size()), 32'd0);
    chk("left_fet", 32'(q_fet.size()), 32'd0);
    chk("left_halt", 32'(q_halt.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
